// File: rtl/reset_mode_pkg.sv
// Shared types for the reset-mode command path.
// Command encodings, sequencer states and the mode-to-domain mask map.
package reset_mode_pkg;

    typedef enum logic [1:0] {
        DEFAULT     = 2'd0,
        NON_DEFAULT = 2'd1,
        DEFAULT0    = 2'd2,
        DEFAULT1    = 2'd3
    } reset_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        STAGE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Bit 0 selects domain 0, bit 1 selects domain 1.
    function automatic logic [1:0] mode_to_mask(input reset_mode_e m);
        logic [1:0] r;
        r = 2'b00;
        unique case (m)
            DEFAULT:     r = 2'b11;
            DEFAULT0:    r = 2'b01;
            DEFAULT1:    r = 2'b10;
            NON_DEFAULT: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reset_mode_sequencer.sv
// Accepts a reset-mode command and drives a staged assert/release
// sequence onto two downstream reset domains.
module reset_mode_sequencer
    import reset_mode_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_GAP   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_valid,
    input  logic [1:0] mode,
    output logic       mode_ready,
    output logic [1:0] rst_dom,
    output logic       busy,
    output logic       done
);

    localparam int MAXC  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    seq_state_e       state, state_n;
    logic [1:0]       mask, mask_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       dom_n;

    assign mode_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        mask_n  = mask;
        cnt_n   = cnt + CNT_W'(1);
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (mode_valid) begin
                    mask_n  = mode_to_mask(reset_mode_e'(mode));
                    state_n = (mask_n != 2'b00) ? HOLD : DONE;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = (mask == 2'b11) ? STAGE : DONE;
                end
            end
            STAGE: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        dom_n = 2'b00;
        unique case (1'b1)
            (state_n == HOLD):  dom_n = mask_n;
            (state_n == STAGE): dom_n = 2'b10;
            default:            dom_n = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= HOLD;
            mask    <= 2'b11;
            cnt     <= '0;
            rst_dom <= 2'b11;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mask    <= mask_n;
            cnt     <= cnt_n;
            rst_dom <= dom_n;
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_reset_mode_sequencer.sv
// Directed vector bench for reset_mode_sequencer.
// Table-driven main flow plus a hand-written mid-sequence reset case.
module tb_reset_mode_sequencer;

    import reset_mode_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode_valid;
    logic [1:0] mode;
    logic       mode_ready;
    logic [1:0] rst_dom;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        string      tag;
        logic       rst;
        logic       vld;
        logic [1:0] md;
        logic       rdy;
        logic [1:0] dom;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_cnt++;

    reset_mode_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .mode_valid (mode_valid),
        .mode       (mode),
        .mode_ready (mode_ready),
        .rst_dom    (rst_dom),
        .busy       (busy),
        .done       (done)
    );

    function automatic vec_t mk(string t, logic r, logic v, logic [1:0] m,
                                logic rd, logic [1:0] d, logic b, logic dn);
        vec_t x;
        x.tag = t; x.rst = r; x.vld = v; x.md = m;
        x.rdy = rd; x.dom = d; x.bsy = b; x.dn = dn;
        return x;
    endfunction

    function automatic void add(int n, string t, logic r, logic v, logic [1:0] m,
                                logic rd, logic [1:0] d, logic b, logic dn);
        for (int i = 0; i < n; i++) vecs.push_back(mk(t, r, v, m, rd, d, b, dn));
    endfunction

    task automatic apply(input vec_t x);
        reset      = x.rst;
        mode_valid = x.vld;
        mode       = x.md;
        @(posedge clock);
        #1;
        checks++;
        if ({mode_ready, rst_dom, busy, done} !== {x.rdy, x.dom, x.bsy, x.dn}) begin
            failures++;
            $display("FAIL %s: ready/rst_dom/busy/done got %b/%b/%b/%b want %b/%b/%b/%b",
                     x.tag, mode_ready, rst_dom, busy, done, x.rdy, x.dom, x.bsy, x.dn);
        end
    endtask

    task automatic check_int(input string t, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", t, got, want);
        end
    endtask

    initial begin
        int base;
        reset      = 1'b1;
        mode_valid = 1'b0;
        mode       = 2'd0;

        // power-on DEFAULT sequence
        add(3, "por_rst",   1, 0, 0, 0, 2'b11, 1, 0);
        add(7, "por_hold",  0, 0, 0, 0, 2'b11, 1, 0);
        add(4, "por_stage", 0, 0, 0, 0, 2'b10, 1, 0);
        add(1, "por_done",  0, 0, 0, 0, 2'b00, 1, 1);
        add(1, "por_idle",  0, 0, 0, 1, 2'b00, 0, 0);
        // DEFAULT0
        add(1, "d0_acc",    0, 1, 2, 0, 2'b01, 1, 0);
        add(7, "d0_hold",   0, 0, 0, 0, 2'b01, 1, 0);
        add(1, "d0_done",   0, 0, 0, 0, 2'b00, 1, 1);
        add(1, "d0_idle",   0, 0, 0, 1, 2'b00, 0, 0);
        // NON_DEFAULT
        add(1, "nd_acc",    0, 1, 1, 0, 2'b00, 1, 1);
        add(1, "nd_idle",   0, 0, 0, 1, 2'b00, 0, 0);
        add(2, "idle_quiet",0, 0, 0, 1, 2'b00, 0, 0);
        // DEFAULT1 held off while a DEFAULT runs
        add(1, "dflt_acc",   0, 1, 0, 0, 2'b11, 1, 0);
        add(7, "stall_hold", 0, 1, 3, 0, 2'b11, 1, 0);
        add(4, "stall_stage",0, 1, 3, 0, 2'b10, 1, 0);
        add(1, "stall_done", 0, 1, 3, 0, 2'b00, 1, 1);
        add(1, "stall_idle", 0, 1, 3, 1, 2'b00, 0, 0);
        add(1, "d1_acc",     0, 1, 3, 0, 2'b10, 1, 0);
        add(7, "d1_hold",    0, 0, 0, 0, 2'b10, 1, 0);
        add(1, "d1_done",    0, 0, 0, 0, 2'b00, 1, 1);
        add(1, "d1_idle",    0, 0, 0, 1, 2'b00, 0, 0);
        // back-to-back valid, DEFAULT0 then DEFAULT1
        add(1, "b2b_acc0",  0, 1, 2, 0, 2'b01, 1, 0);
        add(7, "b2b_hold0", 0, 1, 3, 0, 2'b01, 1, 0);
        add(1, "b2b_done0", 0, 1, 3, 0, 2'b00, 1, 1);
        add(1, "b2b_idle",  0, 1, 3, 1, 2'b00, 0, 0);
        add(1, "b2b_acc1",  0, 1, 3, 0, 2'b10, 1, 0);
        add(7, "b2b_hold1", 0, 0, 0, 0, 2'b10, 1, 0);
        add(1, "b2b_done1", 0, 0, 0, 0, 2'b00, 1, 1);
        add(1, "b2b_end",   0, 0, 0, 1, 2'b00, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);
        check_int("table_done_pulses", done_cnt, 7);

        // reset during STAGE of a DEFAULT sequence
        base = done_cnt;
        apply(mk("mr_acc", 0, 1, 0, 0, 2'b11, 1, 0));
        for (int i = 0; i < 7; i++) apply(mk("mr_hold", 0, 0, 0, 0, 2'b11, 1, 0));
        for (int i = 0; i < 2; i++) apply(mk("mr_stage", 0, 0, 0, 0, 2'b10, 1, 0));
        apply(mk("mr_reset", 1, 0, 0, 0, 2'b11, 1, 0));
        check_int("mr_no_done_abandoned", done_cnt - base, 0);
        for (int i = 0; i < 7; i++) apply(mk("mr_por_hold", 0, 0, 0, 0, 2'b11, 1, 0));
        for (int i = 0; i < 4; i++) apply(mk("mr_por_stage", 0, 0, 0, 0, 2'b10, 1, 0));
        apply(mk("mr_por_done", 0, 0, 0, 0, 2'b00, 1, 1));
        apply(mk("mr_por_idle", 0, 0, 0, 1, 2'b00, 0, 0));
        check_int("mr_done_after_restart", done_cnt - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
